// File: rtl/siganfu_machine_gun.sv
// Fire-control FSM for a machine gun.
// It tracks rounds in the magazine and the spare magazines, runs the
// reload and barrel-cooldown timers, and registers every output.
module siganfu_machine_gun (
  input  logic       sysclk,
  input  logic       reboot,
  input  logic       is_enemy,
  input  logic       target_locked,
  input  logic       fire_command,
  input  logic       firing_mode,
  input  logic       overheat_sensor,
  output logic [2:0] current_state,
  output logic       criticality_alert,
  output logic       fire_trigger
);

  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_RELOAD   = 3'b001;
  localparam logic [2:0] S_LOCKED   = 3'b010;
  localparam logic [2:0] S_FIRE     = 3'b011;
  localparam logic [2:0] S_COOLDOWN = 3'b100;
  localparam logic [2:0] S_OOA      = 3'b101;

  localparam logic [4:0] MAG_FULL     = 5'd25;
  localparam logic [1:0] SPARES_INIT  = 2'd2;
  // Timers count from 0, so these are the last index of each phase.
  localparam logic [2:0] RELOAD_LAST  = 3'd4;   // RELOAD lasts 5 cycles
  localparam logic [3:0] COOL_MIN     = 4'd9;   // COOLDOWN lasts >= 10 cycles

  logic [2:0] state_q, state_d;
  logic [4:0] rounds_q, rounds_d;
  logic [1:0] spares_q, spares_d;
  logic [2:0] reload_cnt_q, reload_cnt_d;
  logic [3:0] cool_cnt_q, cool_cnt_d;
  logic       fire_prev_q;
  logic       alert_q, alert_d;
  logic       fire_q, fire_d;

  logic       engage;
  logic       fire_req;
  logic [2:0] empty_dest;
  logic [2:0] resume_dest;

  assign engage      = is_enemy & target_locked;
  // Auto mode fires on level; single-shot fires only on a fresh press.
  assign fire_req    = firing_mode ? fire_command : (fire_command & ~fire_prev_q);
  assign empty_dest  = (spares_q != 2'd0) ? S_RELOAD : S_OOA;
  assign resume_dest = engage ? S_LOCKED : S_IDLE;

  // State register, counters, timers and registered outputs.
  always_ff @(posedge sysclk or negedge reboot) begin
    if (!reboot) begin
      state_q      <= S_IDLE;
      rounds_q     <= MAG_FULL;
      spares_q     <= SPARES_INIT;
      reload_cnt_q <= 3'd0;
      cool_cnt_q   <= 4'd0;
      fire_prev_q  <= 1'b0;
      alert_q      <= 1'b0;
      fire_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rounds_q     <= rounds_d;
      spares_q     <= spares_d;
      reload_cnt_q <= reload_cnt_d;
      cool_cnt_q   <= cool_cnt_d;
      fire_prev_q  <= fire_command;
      alert_q      <= alert_d;
      fire_q       <= fire_d;
    end
  end

  // Next-state selection, highest-priority condition first in each state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (overheat_sensor)  state_d = S_COOLDOWN;
        else if (engage)      state_d = S_LOCKED;
      end
      S_LOCKED: begin
        if (overheat_sensor)        state_d = S_COOLDOWN;
        else if (!engage)           state_d = S_IDLE;
        else if (rounds_q == 5'd0)  state_d = empty_dest;
        else if (fire_req)          state_d = S_FIRE;
      end
      S_FIRE: begin
        // The round shot this cycle empties the magazine when rounds_q <= 1.
        if (overheat_sensor)                  state_d = S_COOLDOWN;
        else if (rounds_q <= 5'd1)            state_d = empty_dest;
        else if (!firing_mode)                state_d = S_LOCKED;
        else if (!(fire_command && engage))   state_d = S_LOCKED;
      end
      S_RELOAD: begin
        if (reload_cnt_q == RELOAD_LAST) state_d = resume_dest;
      end
      S_COOLDOWN: begin
        if ((cool_cnt_q >= COOL_MIN) && !overheat_sensor) begin
          if (rounds_q == 5'd0) state_d = empty_dest;
          else                  state_d = resume_dest;
        end
      end
      S_OOA:   state_d = S_OOA;
      default: state_d = S_IDLE;
    endcase
  end

  // Ammunition counters and phase timers; timers clear outside their phase.
  always_comb begin
    rounds_d     = rounds_q;
    spares_d     = spares_q;
    reload_cnt_d = 3'd0;
    cool_cnt_d   = 4'd0;
    case (state_q)
      S_FIRE: begin
        if (rounds_q != 5'd0) rounds_d = rounds_q - 5'd1;
      end
      S_RELOAD: begin
        if (reload_cnt_q == RELOAD_LAST) begin
          rounds_d = MAG_FULL;
          if (spares_q != 2'd0) spares_d = spares_q - 2'd1;
        end else begin
          reload_cnt_d = reload_cnt_q + 3'd1;
        end
      end
      S_COOLDOWN: begin
        cool_cnt_d = (cool_cnt_q >= COOL_MIN) ? cool_cnt_q : cool_cnt_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    alert_d = (state_d == S_COOLDOWN) || (state_d == S_OOA);
    fire_d  = (state_d == S_FIRE);
  end

  assign current_state     = state_q;
  assign criticality_alert = alert_q;
  assign fire_trigger      = fire_q;

endmodule

// File: tb/tb_siganfu_machine_gun.sv
// Bench for siganfu_machine_gun: directed scenarios followed by a random
// run, all compared cycle by cycle against a behavioural model.
module tb_siganfu_machine_gun;

  logic       sysclk = 1'b0;
  logic       reboot;
  logic       is_enemy, target_locked, fire_command, firing_mode, overheat_sensor;
  logic [2:0] current_state;
  logic       criticality_alert, fire_trigger;

  int n_err    = 0;
  int n_checks = 0;

  siganfu_machine_gun dut (
    .sysclk           (sysclk),
    .reboot           (reboot),
    .is_enemy         (is_enemy),
    .target_locked    (target_locked),
    .fire_command     (fire_command),
    .firing_mode      (firing_mode),
    .overheat_sensor  (overheat_sensor),
    .current_state    (current_state),
    .criticality_alert(criticality_alert),
    .fire_trigger     (fire_trigger)
  );

  // Clock and watchdog.
  always #5 sysclk = ~sysclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: phase-based description of the weapon's behaviour.
  localparam int IDLE = 0, RELOAD = 1, LOCKED = 2, FIRE = 3, COOL = 4, EMPTY = 5;
  int m_st, m_rounds, m_spares, m_phase;
  bit m_prev_fire;

  task automatic model_reset();
    m_st = IDLE; m_rounds = 25; m_spares = 2; m_phase = 0; m_prev_fire = 0;
  endtask

  task automatic model_clock();
    bit engage;
    bit req;
    int nxt;
    int when_empty;
    engage     = is_enemy && target_locked;
    req        = firing_mode ? fire_command : (fire_command && !m_prev_fire);
    nxt        = m_st;
    when_empty = (m_spares > 0) ? RELOAD : EMPTY;
    if (m_st == IDLE) begin
      if (overheat_sensor) nxt = COOL;
      else if (engage)     nxt = LOCKED;
    end else if (m_st == LOCKED) begin
      if (overheat_sensor)    nxt = COOL;
      else if (!engage)       nxt = IDLE;
      else if (m_rounds == 0) nxt = when_empty;
      else if (req)           nxt = FIRE;
    end else if (m_st == FIRE) begin
      if (m_rounds > 0) m_rounds = m_rounds - 1;
      if (overheat_sensor)                  nxt = COOL;
      else if (m_rounds == 0)               nxt = when_empty;
      else if (!firing_mode)                nxt = LOCKED;
      else if (fire_command && engage)      nxt = FIRE;
      else                                  nxt = LOCKED;
    end else if (m_st == RELOAD) begin
      m_phase = m_phase + 1;
      if (m_phase == 5) begin
        m_rounds = 25;
        if (m_spares > 0) m_spares = m_spares - 1;
        nxt = engage ? LOCKED : IDLE;
      end
    end else if (m_st == COOL) begin
      m_phase = m_phase + 1;
      if (m_phase >= 10 && !overheat_sensor) begin
        if (m_rounds == 0) nxt = when_empty;
        else               nxt = engage ? LOCKED : IDLE;
      end
    end
    if (nxt != m_st) m_phase = 0;
    m_st        = nxt;
    m_prev_fire = fire_command;
  endtask

  // Scoreboard helpers.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    check("state", {29'd0, current_state}, m_st);
    check("alert", {31'd0, criticality_alert}, (m_st == COOL || m_st == EMPTY) ? 1 : 0);
    check("fire",  {31'd0, fire_trigger},      (m_st == FIRE) ? 1 : 0);
  endtask

  // One clock: inputs were set at the previous negedge; check at the next.
  task automatic step();
    @(posedge sysclk);
    if (reboot) model_clock();
    @(negedge sysclk);
    compare_model();
  endtask

  // Reset pulsed between clock edges; outputs must clear without an edge.
  task automatic async_reset_pulse();
    #2 reboot = 1'b0;
    model_reset();
    #1;
    check("rst_state", {29'd0, current_state}, 0);
    check("rst_alert", {31'd0, criticality_alert}, 0);
    check("rst_fire",  {31'd0, fire_trigger}, 0);
    @(negedge sysclk);
    reboot = 1'b1;
  endtask

  task automatic set_inputs(input bit en, input bit lk, input bit fc, input bit md, input bit oh);
    is_enemy = en; target_locked = lk; fire_command = fc; firing_mode = md; overheat_sensor = oh;
  endtask

  task automatic wait_state(input logic [2:0] code);
    int guard;
    guard = 0;
    while (current_state !== code && guard < 300) begin step(); guard++; end
  endtask

  task automatic measure_run(input logic [2:0] code, output int n);
    n = 0;
    wait_state(code);
    while (current_state === code && n < 300) begin n++; step(); end
  endtask

  // Directed scenarios, then randomized operation.
  initial begin
    int n;
    int pulses;
    int hold;
    reboot = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    model_reset();
    @(negedge sysclk);
    @(negedge sysclk);
    check("reset_state", {29'd0, current_state}, 0);
    check("reset_alert", {31'd0, criticality_alert}, 0);
    check("reset_fire",  {31'd0, fire_trigger}, 0);

    // Auto burst: 25 rounds, 5-cycle reload, then firing resumes.
    set_inputs(1, 1, 1, 1, 0);
    reboot = 1'b1;
    step();
    check("burst_locked", {29'd0, current_state}, 3'b010);
    measure_run(3'b011, n);
    check("burst_len", n, 25);
    measure_run(3'b001, n);
    check("reload_len", n, 5);
    check("after_reload", {29'd0, current_state}, 3'b010);
    step();
    check("fire_resumes", {29'd0, current_state}, 3'b011);

    // Single shot: one pulse per press, magazine left with 23.
    async_reset_pulse();
    set_inputs(1, 1, 0, 0, 0);
    step(); step();
    fire_command = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin step(); if (fire_trigger) pulses++; end
    check("single_first", pulses, 1);
    fire_command = 1'b0;
    for (int i = 0; i < 3; i++) step();
    fire_command = 1'b1;
    for (int i = 0; i < 20; i++) begin step(); if (fire_trigger) pulses++; end
    check("single_second", pulses, 2);
    firing_mode = 1'b1;
    measure_run(3'b011, n);
    check("single_remaining", n, 23);

    // Overheat on the last round: cooldown, then reload, then a full magazine.
    async_reset_pulse();
    set_inputs(1, 1, 1, 1, 0);
    wait_state(3'b011);
    for (int i = 0; i < 24; i++) step();
    overheat_sensor = 1'b1;
    step();
    check("oh_cooldown", {29'd0, current_state}, 3'b100);
    check("oh_alert", {31'd0, criticality_alert}, 1);
    for (int i = 0; i < 9; i++) step();
    overheat_sensor = 1'b0;
    measure_run(3'b001, n);
    check("oh_reload_len", n, 5);
    measure_run(3'b011, n);
    check("oh_refire_len", n, 25);

    // Ammo exhaustion: 75 rounds then terminal until reboot.
    async_reset_pulse();
    set_inputs(1, 1, 1, 1, 0);
    pulses = 0;
    for (int i = 0; i < 400 && current_state !== 3'b101; i++) begin
      step();
      if (fire_trigger) pulses++;
    end
    check("exhaust_rounds", pulses, 75);
    check("exhaust_alert", {31'd0, criticality_alert}, 1);
    for (int i = 0; i < 20; i++) step();
    check("exhaust_hold", {29'd0, current_state}, 3'b101);
    async_reset_pulse();
    check("exhaust_reboot", {29'd0, current_state}, 3'b000);
    measure_run(3'b011, n);
    check("exhaust_full_mag", n, 25);

    // Lock loss mid-burst.
    async_reset_pulse();
    set_inputs(1, 1, 1, 1, 0);
    wait_state(3'b011);
    step(); step();
    target_locked = 1'b0;
    step();
    check("lock_loss_locked", {29'd0, current_state}, 3'b010);
    check("lock_loss_fire", {31'd0, fire_trigger}, 0);
    step();
    check("lock_loss_idle", {29'd0, current_state}, 3'b000);

    // Reset mid-FIRE and mid-COOLDOWN.
    target_locked = 1'b1;
    wait_state(3'b011);
    step();
    async_reset_pulse();
    wait_state(3'b011);
    overheat_sensor = 1'b1;
    step();
    step(); step();
    async_reset_pulse();
    overheat_sensor = 1'b0;
    check("post_rst_idle", {29'd0, current_state}, 3'b000);

    // Random operation with occasional overheat spells and reboots.
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      is_enemy      = ($urandom_range(0, 9) != 0);
      target_locked = ($urandom_range(0, 9) != 0);
      fire_command  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) firing_mode = ~firing_mode;
      if (hold > 0) hold--;
      else if ($urandom_range(0, 39) == 0) hold = $urandom_range(1, 14);
      overheat_sensor = (hold > 0);
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
